// File: rtl/sqrt_controller.sv
// sqrt_controller: control unit for the 8-bit square-root/magnitude datapath.
// Sequences ABSA, ABSB, MAX, MIN, SUB, ADD and FMAX. Each compute state lasts
// AU_LAT cycles, and its register enables fire only in the last of them.
// Optional feature macro: SQRT_CTRL_ERR_EN adds a sticky `err` output that
// flags a start while busy or a 2-bit bus enable of 11.
module sqrt_controller #(
  parameter int AU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       en_R1,
  output logic       en_R2,
  output logic       en_R3,
  output logic       en_R4,
  output logic       en_R5,
  output logic       b1,
  output logic [1:0] b2,
  output logic [1:0] b3,
  output logic [1:0] b4,
  output logic [1:0] b5,
  output logic       b6,
  output logic [1:0] b7,
  output logic [1:0] sel_AU1,
  output logic [1:0] sel_AU2,
  output logic       Done
`ifdef SQRT_CTRL_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, ABSA = 4'd1, ABSB = 4'd2, MAX = 4'd3, MIN = 4'd4,
    SUB  = 4'd5, ADD  = 4'd6, FMAX = 4'd7, DONE = 4'd8
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       en_r1;
    logic       en_r2;
    logic       en_r3;
    logic       en_r4;
    logic       en_r5;
    logic       b1;
    logic [1:0] b2;
    logic [1:0] b3;
    logic [1:0] b4;
    logic [1:0] b5;
    logic       b6;
    logic [1:0] b7;
    logic [1:0] sel_au1;
    logic [1:0] sel_au2;
    logic       done;
  } ctrl_t;

  localparam logic [1:0] LAST_CNT = 2'(AU_LAT - 1);

  state_t     state_r, state_nxt_s;
  logic [1:0] cnt_r, cnt_nxt_s;
  logic       last_s;
  ctrl_t      ctrl_r;
  logic       mealy_s;

  // Control word seen while sitting in `st`; `last` marks the final cycle.
  function automatic ctrl_t decode(input state_t st, input logic last);
    ctrl_t c;
    c = {$bits(ctrl_t){1'b0}};
    c.busy = 1'b1;
    case (st)
      ABSA: begin c.b1 = 1'b1; c.sel_au1 = 2'b00; c.b3 = 2'b01; c.en_r1 = last; end
      ABSB: begin c.b2 = 2'b01; c.sel_au1 = 2'b01; c.b4 = 2'b01; c.en_r2 = last; end
      MAX:  begin
        c.b1 = 1'b1; c.b2 = 2'b01; c.sel_au1 = 2'b10; c.b7 = 2'b10;
        c.en_r4 = last; c.en_r3 = last;
      end
      MIN:  begin c.b1 = 1'b1; c.b2 = 2'b01; c.sel_au1 = 2'b11; c.en_r5 = last; end
      SUB:  begin
        c.b5 = 2'b10; c.b6 = 1'b1; c.sel_au2 = 2'b00; c.b7 = 2'b01; c.en_r3 = last;
      end
      ADD:  begin
        c.b5 = 2'b01; c.b6 = 1'b1; c.sel_au2 = 2'b01; c.b7 = 2'b01; c.en_r3 = last;
      end
      FMAX: begin
        c.b5 = 2'b10; c.b6 = 1'b1; c.sel_au2 = 2'b10; c.b7 = 2'b01; c.en_r3 = last;
      end
      DONE: begin c.busy = 1'b0; c.done = 1'b1; end
      default: c.busy = 1'b0;
    endcase
    return c;
  endfunction

  assign last_s = (cnt_r == LAST_CNT);

  // State and per-state cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: accept start only when idle/done, advance on the last cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s = ABSA;
        end else begin
          state_nxt_s = state_r;
        end
        cnt_nxt_s = 2'd0;
      end
      ABSA, ABSB, MAX, MIN, SUB, ADD, FMAX: begin
        if (last_s) begin
          state_nxt_s = state_t'(state_r + 4'd1);
          cnt_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = state_r;
          cnt_nxt_s   = cnt_r + 2'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 2'd0;
      end
    endcase
  end

  // Control word is registered from the upcoming state so outputs are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r <= {$bits(ctrl_t){1'b0}};
    end else begin
      ctrl_r <= decode(state_nxt_s, cnt_nxt_s == LAST_CNT);
    end
  end

  // Operand-capture terms in IDLE/DONE follow start directly, and are held off in reset.
  assign mealy_s = ((state_r == IDLE) || (state_r == DONE)) && !rst;

  assign busy    = ctrl_r.busy;
  assign en_R1   = ctrl_r.en_r1 | (mealy_s & start);
  assign en_R2   = ctrl_r.en_r2 | (mealy_s & start);
  assign en_R3   = ctrl_r.en_r3;
  assign en_R4   = ctrl_r.en_r4;
  assign en_R5   = ctrl_r.en_r5;
  assign b1      = ctrl_r.b1;
  assign b2      = ctrl_r.b2;
  assign b3      = mealy_s ? 2'b10 : ctrl_r.b3;
  assign b4      = mealy_s ? 2'b10 : ctrl_r.b4;
  assign b5      = ctrl_r.b5;
  assign b6      = ctrl_r.b6;
  assign b7      = ctrl_r.b7;
  assign sel_AU1 = ctrl_r.sel_au1;
  assign sel_AU2 = ctrl_r.sel_au2;
  assign Done    = ctrl_r.done;

`ifdef SQRT_CTRL_ERR_EN
  logic err_r;
  logic bus_clash_s;

  assign bus_clash_s = (b2 == 2'b11) || (b3 == 2'b11) || (b4 == 2'b11) ||
                       (b5 == 2'b11) || (b7 == 2'b11);

  // Sticky error: start while busy, or two drivers enabled on one bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((start && ctrl_r.busy) || bus_clash_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`endif

endmodule
